// File: rtl/smoldvi_timing_pkg.sv
// SmolDVI timing: shared axis state encoding, 640x480@60 defaults,
// and sizing helpers for the per-axis counters.
package smoldvi_timing_pkg;

   localparam logic [1:0] AX_SYNC   = 2'd0;
   localparam logic [1:0] AX_BACK   = 2'd1;
   localparam logic [1:0] AX_ACTIVE = 2'd2;
   localparam logic [1:0] AX_FRONT  = 2'd3;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   function automatic int axis_total(input int a, input int b,
                                     input int c, input int d);
      return a + b + c + d;
   endfunction

   // Narrowest counter holding 0..longest-1; never below one bit.
   function automatic int axis_cnt_w(input int a, input int b,
                                     input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/smoldvi_timing_axis.sv
// One timing axis: SYNC -> BACK -> ACTIVE -> FRONT state with a
// count inside the current state; advances only when adv is high.
module smoldvi_timing_axis
   import smoldvi_timing_pkg::*;
#(
   parameter int L_SYNC   = 1,
   parameter int L_BACK   = 1,
   parameter int L_ACTIVE = 1,
   parameter int L_FRONT  = 1,
   parameter int W        = axis_cnt_w(L_SYNC, L_BACK, L_ACTIVE, L_FRONT)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         adv,
   output logic [1:0]   state,
   output logic [W-1:0] count,
   output logic         last_of_axis
);

   logic [W-1:0] lim;
   logic         at_end;

   always_comb begin
      lim = W'(L_SYNC - 1);
      unique case (state)
         AX_BACK:   lim = W'(L_BACK - 1);
         AX_ACTIVE: lim = W'(L_ACTIVE - 1);
         AX_FRONT:  lim = W'(L_FRONT - 1);
         default:   lim = W'(L_SYNC - 1);
      endcase
   end

   assign at_end       = (count == lim);
   assign last_of_axis = (state == AX_FRONT) && at_end;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state <= AX_SYNC;
         count <= '0;
      end else if (adv) begin
         if (at_end) begin
            state <= state + 2'd1;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/smoldvi_timing.sv
// SmolDVI pixel-clock timing generator: registered sync/den outputs
// plus a pixel request with coordinates one cycle ahead of den.
module smoldvi_timing
   import smoldvi_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int W_X      = 10,
   parameter int W_Y      = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   output logic           hsync,
   output logic           vsync,
   output logic           den,
   output logic           pix_req,
   output logic [W_X-1:0] x,
   output logic [W_Y-1:0] y,
   output logic           frame_start
);

   localparam int WH = axis_cnt_w(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
   localparam int WV = axis_cnt_w(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

   if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1)
   begin : g_bad_len
      $error("smoldvi_timing: every porch/sync/active length must be >= 1");
   end

   if ((64'd1 << W_X) < 64'(H_ACTIVE) || (64'd1 << W_Y) < 64'(V_ACTIVE))
   begin : g_bad_w
      $error("smoldvi_timing: W_X/W_Y too narrow for the active area");
   end

   logic [1:0]    h_st;
   logic [1:0]    v_st;
   logic [WH-1:0] h_cnt;
   logic [WV-1:0] v_cnt;
   logic          h_last;
   logic          v_wrap_unused;
   logic          clr;

   assign clr = ~en;

   smoldvi_timing_axis #(
      .L_SYNC   (H_SYNC),
      .L_BACK   (H_BACK),
      .L_ACTIVE (H_ACTIVE),
      .L_FRONT  (H_FRONT),
      .W        (WH)
   ) u_h (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .adv          (1'b1),
      .state        (h_st),
      .count        (h_cnt),
      .last_of_axis (h_last)
   );

   smoldvi_timing_axis #(
      .L_SYNC   (V_SYNC),
      .L_BACK   (V_BACK),
      .L_ACTIVE (V_ACTIVE),
      .L_FRONT  (V_FRONT),
      .W        (WV)
   ) u_v (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .adv          (h_last),
      .state        (v_st),
      .count        (v_cnt),
      .last_of_axis (v_wrap_unused)
   );

   logic           h_nxt_act;
   logic           nxt_act;
   logic           at_origin;
   logic [W_X-1:0] nxt_x;
   logic [W_Y-1:0] cur_y;

   // The next h position can only be active without a line wrap,
   // so the v axis keeps its current line for the request.
   assign h_nxt_act = (h_st == AX_ACTIVE && h_cnt != WH'(H_ACTIVE - 1)) ||
                      (h_st == AX_BACK && h_cnt == WH'(H_BACK - 1));
   assign nxt_act   = h_nxt_act && (v_st == AX_ACTIVE);
   assign nxt_x     = (h_st == AX_ACTIVE) ? W_X'(h_cnt) + 1'b1 : '0;
   assign cur_y     = W_Y'(v_cnt);
   assign at_origin = (h_st == AX_SYNC) && (h_cnt == '0) &&
                      (v_st == AX_SYNC) && (v_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         den         <= 1'b0;
         pix_req     <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= (h_st == AX_SYNC) ? H_POL : ~H_POL;
         vsync       <= (v_st == AX_SYNC) ? V_POL : ~V_POL;
         den         <= pix_req;
         pix_req     <= nxt_act;
         x           <= nxt_act ? nxt_x : '0;
         y           <= nxt_act ? cur_y : '0;
         frame_start <= at_origin;
      end
   end

endmodule

// File: tb/tb_smoldvi_timing.sv
// Bench for smoldvi_timing: three builds checked every cycle against a
// frame-position model, plus literal waveform landmarks.
module tb_smoldvi_timing;
   import smoldvi_timing_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // build 0: defaults
   logic       rst0, en0, hs0, vs0, de0, pr0, fs0;
   logic [9:0] x0, y0;
   // build 1: tiny
   logic       rst1, en1, hs1, vs1, de1, pr1, fs1;
   logic [2:0] x1;
   logic [1:0] y1;
   // build 2: medium, positive hsync
   logic       rst2, en2, hs2, vs2, de2, pr2, fs2;
   logic [3:0] x2;
   logic [2:0] y2;

   smoldvi_timing u_d0 (
      .clk(clk), .rst(rst0), .en(en0), .hsync(hs0), .vsync(vs0),
      .den(de0), .pix_req(pr0), .x(x0), .y(y0), .frame_start(fs0)
   );

   smoldvi_timing #(
      .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
      .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .W_X(3), .W_Y(2)
   ) u_d1 (
      .clk(clk), .rst(rst1), .en(en1), .hsync(hs1), .vsync(vs1),
      .den(de1), .pix_req(pr1), .x(x1), .y(y1), .frame_start(fs1)
   );

   smoldvi_timing #(
      .H_ACTIVE(12), .H_FRONT(3), .H_SYNC(5), .H_BACK(2),
      .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(3), .V_BACK(1),
      .H_POL(1'b1), .V_POL(1'b0), .W_X(4), .W_Y(3)
   ) u_d2 (
      .clk(clk), .rst(rst2), .en(en2), .hsync(hs2), .vsync(vs2),
      .den(de2), .pix_req(pr2), .x(x2), .y(y2), .frame_start(fs2)
   );

   localparam int FT0 = axis_total(96, 48, 640, 16) * axis_total(2, 33, 480, 10);
   localparam int FT1 = axis_total(1, 1, 4, 1) * axis_total(1, 1, 2, 1);
   localparam int FT2 = axis_total(5, 2, 12, 3) * axis_total(3, 1, 6, 2);

   // position inside the frame shown by the outputs; -1 = disabled
   int pos0 = -1;
   int pos1 = -1;
   int pos2 = -1;

   function automatic int step(input bit r, input bit e, input int p, input int ft);
      if (r || !e) return -1;
      return (p < 0) ? 0 : (p + 1) % ft;
   endfunction

   // {hsync, vsync, den, pix_req, frame_start, x[15:0], y[15:0]}
   function automatic logic [36:0] expect_at(
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb,
      input bit hp, input bit vp, input int p);
      int  ht, vt, ft, col, line, n, ncol, nline, xv, yv;
      bit  a, na, h, v;
      if (p < 0) return {~hp, ~vp, 3'b000, 32'd0};
      ht    = hs + hb + ha + hf;
      vt    = vs + vb + va + vf;
      ft    = ht * vt;
      col   = p % ht;
      line  = p / ht;
      n     = (p + 1) % ft;
      ncol  = n % ht;
      nline = n / ht;
      a  = (col >= hs + hb) && (col < hs + hb + ha) &&
           (line >= vs + vb) && (line < vs + vb + va);
      na = (ncol >= hs + hb) && (ncol < hs + hb + ha) &&
           (nline >= vs + vb) && (nline < vs + vb + va);
      h  = (col < hs) ? hp : ~hp;
      v  = (line < vs) ? vp : ~vp;
      xv = na ? ncol - hs - hb : 0;
      yv = na ? nline - vs - vb : 0;
      return {h, v, a, na, (p == 0), 16'(xv), 16'(yv)};
   endfunction

   task automatic cmp(input string nm, input logic [36:0] got,
                      input logic [36:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         if (bad <= 30)
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
      end
   endtask

   task automatic lit(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, exp);
      end
   endtask

   always @(posedge clk) begin
      pos0 = step(rst0, en0, pos0, FT0);
      pos1 = step(rst1, en1, pos1, FT1);
      pos2 = step(rst2, en2, pos2, FT2);
      cyc++;
   end

   localparam int F0 = 35 * 800 + 144;
   int  fs_last = 0;
   bit  fs_have = 1'b0;

   always @(negedge clk) begin
      if (cyc > 0) begin
         cmp("d0", {hs0, vs0, de0, pr0, fs0, 16'(x0), 16'(y0)},
             expect_at(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, pos0));
         cmp("d1", {hs1, vs1, de1, pr1, fs1, 16'(x1), 16'(y1)},
             expect_at(4, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0, pos1));
         cmp("d2", {hs2, vs2, de2, pr2, fs2, 16'(x2), 16'(y2)},
             expect_at(12, 3, 5, 2, 6, 2, 3, 1, 1'b1, 1'b0, pos2));

         if (pos0 == 0)      lit("t0_hs_vs_fs_de", {hs0, vs0, fs0, de0}, 4'b0010);
         if (pos0 == 95)     lit("hs_last_low", hs0, 0);
         if (pos0 == 96)     lit("hs_rise", hs0, 1);
         if (pos0 == 1599)   lit("vs_last_low", vs0, 0);
         if (pos0 == 1600)   lit("vs_rise", vs0, 1);
         if (pos0 == 35*800) lit("line35_hs_fall", {hs0, de0}, 2'b00);
         if (pos0 == F0-1)   lit("first_req", {pr0, de0, x0, y0}, {2'b10, 20'd0});
         if (pos0 == F0)     lit("first_den", {de0, pr0, x0}, {2'b11, 10'd1});
         if (pos0 == F0+638) lit("x_639", {pr0, x0, y0}, {1'b1, 10'd639, 10'd0});
         if (pos0 == F0+639) lit("last_den", {de0, pr0, x0}, {2'b10, 10'd0});
         if (pos0 == F0+640) lit("den_fall", de0, 0);
         if (pos2 == 0)      lit("d2_pol", {hs2, vs2, fs2}, 3'b101);

         if (pos1 < 0) fs_have = 1'b0;
         if (fs1) begin
            if (fs_have) lit("d1_fs_period", cyc - fs_last, 35);
            fs_last = cyc;
            fs_have = 1'b1;
         end
      end
   end

   int d1 = 0;
   int d2 = 0;

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      en0  = 1'b1; en1  = 1'b1; en2  = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      for (int c = 0; c < 29000; c++) begin
         @(posedge clk);
         #2;
         rst1 = (c == 300) || (c > 2000 && $urandom_range(0, 399) == 0);
         if (c == 600) d1 = 5;
         if (d1 > 0) begin
            en1 = 1'b0;
            d1--;
         end else begin
            en1 = 1'b1;
            if (c > 2000 && $urandom_range(0, 149) == 0)
               d1 = $urandom_range(1, 6);
         end
         rst2 = ($urandom_range(0, 499) == 0);
         if (d2 > 0) begin
            en2 = 1'b0;
            d2--;
         end else begin
            en2 = 1'b1;
            if ($urandom_range(0, 199) == 0) d2 = $urandom_range(1, 8);
         end
      end
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/smoldvi_timing.md
Name: smoldvi_timing

Overview:
Pixel-clock-domain video timing generator for the SmolDVI output path.
- Produces hsync, vsync and data-enable for the TMDS encoders that drive the dvi_p/dvi_n pairs.
- Produces an early pixel request with x/y coordinates, so the upstream framebuffer or pattern source can present pixel data in time.
- Defaults give 640x480@60 (800x525 total, 25.2 MHz pixel clock).

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync width (cycles)
H_BACK, 48, horizontal back porch (cycles)
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = negative)
V_POL, 0, vsync active level (0 = negative)
W_X, 10, width of x output (at least clog2 of H_ACTIVE)
W_Y, 10, width of y output (at least clog2 of V_ACTIVE)

Ports:
clk  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
en  in  1  run enable; low holds the generator at frame start
hsync  out  1  horizontal sync at H_POL level while asserted
vsync  out  1  vertical sync at V_POL level while asserted
den  out  1  data enable (active pixel)
pix_req  out  1  high exactly one cycle before each den-high cycle
x  out  W_X  column of the pixel being requested; valid while pix_req is high, else 0
y  out  W_Y  line of the pixel being requested; valid while pix_req is high, else 0
frame_start  out  1  one-cycle pulse on the first hsync cycle of the first vsync line

Behaviour:
- Reset and disabled state: while rst=1 or en=0, on every clk edge:
  - both counters go to frame start (h state SYNC count 0, v state SYNC count 0);
  - hsync=~H_POL, vsync=~V_POL, den=0, pix_req=0, x=0, y=0, frame_start=0.
  - rst has priority over en.
- Per-axis states, cycled SYNC -> BACK -> ACTIVE -> FRONT -> SYNC.
  - A state lasts its parameter count: cycles for h, lines for v.
  - Counter width is clog2 of the largest count.
- Advance rules:
  - The h axis advances every cycle while en=1.
  - The v axis advances only on the cycle h leaves FRONT (the last cycle of the line).
  - Both counters wrap together after the final FRONT cycle.
- Outputs are registered from counter state, with one-cycle latency.
  - Let T0 be the first edge with rst=0 and en=1.
  - After edge T0, the outputs show position (h SYNC 0, v SYNC 0): hsync and vsync active, frame_start=1.
- pix_req and x/y:
  - Registered from the next position (h ACTIVE and v ACTIVE).
  - They therefore lead den by exactly one cycle.
  - x counts 0..H_ACTIVE-1 and y counts 0..V_ACTIVE-1.
- den is a pure one-cycle delay of pix_req.
- vsync edges coincide with hsync leading edges.
- Exactly one frame_start pulse per frame; pulse period H_TOTAL*V_TOTAL cycles.
- en dropped mid-frame: the next edge snaps to the disabled state. On re-enable, the generator restarts from frame start (identical to release from rst).
- rst mid-frame: same as en drop; no partial line is emitted.
- Every porch/sync parameter is at least 1; this is enforced by an elaboration-time check.

Decomposition:
- Package smoldvi_timing_pkg holds:
  - the axis state encoding (SYNC=0, BACK=1, ACTIVE=2, FRONT=3);
  - the 640x480@60 default constants;
  - a helper function for the total count.
- Sub-module smoldvi_timing_axis holds one state plus counter and is instantiated twice (h and v).
  - Inputs: clk, rst, clr, adv.
  - Outputs: state, count, last_of_axis.
  - Parameters: the four lengths.

Test Plan:
- Reset release with en=1 -> edge after T0 gives hsync=0, vsync=0, frame_start=1, den=0; hsync stays low for 96 cycles, then goes high.
- First den rises 96+48=144 cycles after hsync falls on line 35 (V_SYNC+V_BACK). pix_req rises one cycle earlier with x=0, y=0; x reaches 639 on the last pix_req cycle of the line.
- Free run over 3 frames -> frame_start period 420000 cycles, 480 den lines per frame, 640 den cycles per line. vsync low for exactly 1600 cycles, and its edges align with hsync falling edges.
- en deasserted at line 200, pixel 300, then reasserted after 5 cycles -> outputs inactive during the gap; the edge after re-enable shows frame_start=1 and hsync/vsync active.
- rst asserted for 1 cycle mid-active -> the next cycle shows hsync=1, vsync=1, den=0, x=y=0; the sequence then replays from the frame start.
- Small-parameter build (H_ACTIVE=4, H_FRONT=H_SYNC=H_BACK=1, V_ACTIVE=2, all V porches 1) -> 7-cycle lines, 5-line frames (35-cycle frame_start period), and exact waveform match against a cycle-accurate model.
